perf_frame_serializer: RTL and testbench
========================================

Name: perf_frame_serializer

Overview:
- Sits between the cache performance counter bank and the UART transmitter.
- On a rising edge of cpu_done it snapshots every event counter and emits a fixed frame, one byte per handshake, to the UART TX byte interface.
- Frame layout: header byte, each counter MSB-byte-first in index order (counter 0 first), then an XOR checksum byte.

Parameters:
- NUM_CNT, 8, number of counters in the frame. Index order: read_C_L1I, miss_L1I_C, read_C_L1D, write_C_L1D, miss_L1D_C, read_L1_L2, write_L1_L2, miss_L2_L1.
- CNT_W, 32, width of each counter; must be a multiple of 8.
- HEADER, 8'hA5, frame start byte.

Ports:
- clk, input, 1, system clock.
- rstn, input, 1, asynchronous active-low reset.
- cpu_done, input, 1, level from CPU; a rising edge requests one frame.
- cnt_i, input, NUM_CNT*CNT_W, flat counter bus; counter k occupies bits [k*CNT_W +: CNT_W].
- tx_ready, input, 1, UART TX can accept a byte this cycle.
- tx_valid, output, 1, tx_byte holds a byte to send.
- tx_byte, output, 8, byte to transmit.
- frame_busy, output, 1, high from trigger until frame_done.
- frame_done, output, 1, one-cycle pulse after the checksum byte is accepted.

Behaviour:
- Reset (async, rstn=0):
  - FSM to IDLE.
  - tx_valid=0, tx_byte=0, frame_busy=0, frame_done=0.
  - Snapshot register, byte index and checksum cleared.
  - cpu_done_d cleared to 1, so cpu_done already high at reset release does not trigger a frame.
- Trigger:
  - trig = cpu_done & ~cpu_done_d, sampled in IDLE only.
  - At that clock edge: cnt_i is captured into the snapshot, checksum is cleared, the FSM moves to HDR, and frame_busy becomes 1.
  - tx_valid=1 with tx_byte=HEADER from the next cycle (trigger-to-first-valid latency 1 cycle).
- Handshake:
  - A byte transfers on a cycle where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_byte is held stable.
  - The next byte is presented in the cycle after acceptance; no bubble is required.
  - tx_valid never drops without a transfer, except on reset.
- FSM states:
  - IDLE -> HDR on trig.
  - HDR -> DATA on accept.
  - DATA: byte index b runs 0 .. NUM_CNT*CNT_W/8-1. Byte b = snapshot counter b/(CNT_W/8), byte (CNT_W/8-1 - b%(CNT_W/8)) (MSB first). Each accepted data byte is XORed into the checksum. On accept of the last data byte -> CSUM.
  - CSUM: tx_byte = XOR of all data bytes (header excluded). On accept -> DONE.
  - DONE: frame_done=1 for exactly one cycle, frame_busy=0, tx_valid=0 -> IDLE.
- Frame length with defaults: 34 bytes (1 header + 32 data + 1 checksum).
- Boundary rules:
  - cnt_i changing during a frame has no effect; only the snapshot is sent.
  - Rising edges of cpu_done while not in IDLE are ignored and not queued.
  - cpu_done held high after a frame does not retrigger; it must go low then high again.
  - A rising edge coinciding with the DONE cycle is ignored.
  - Reset mid-frame aborts immediately; no partial completion and no frame_done.
  - tx_ready high while tx_valid=0 is ignored.
  - Byte index width is clog2(NUM_CNT*CNT_W/8); no wrap occurs inside a frame.

Decomposition:
- Shared package:
  - state enum (IDLE, HDR, DATA, CSUM, DONE);
  - HEADER default;
  - localparam BYTES_PER_CNT = CNT_W/8;
  - localparam DATA_BYTES = NUM_CNT*BYTES_PER_CNT.
- One natural sub-module, perf_byte_mux: combinational selection of data byte b from the snapshot.
- The FSM, edge detector, checksum and handshake stay in the top.

Test Plan:
- Basic frame:
  - Stimulus: counters 0..7 = 32'h00000001 .. 32'h00000008, tx_ready tied 1, cpu_done 0->1.
  - Required: bytes A5, 00 00 00 01, 00 00 00 02, ..., 00 00 00 08, checksum 08; frame_done at cycle 36 after trigger; frame_busy high throughout.
- Back-pressure:
  - Stimulus: same counters, tx_ready high one cycle in every 10.
  - Required: identical 34-byte sequence; tx_byte stable while stalled; no byte duplicated or dropped.
- Snapshot isolation:
  - Stimulus: counter0 = 32'h12345678 at trigger, then changed to 32'hFFFFFFFF mid-frame.
  - Required: bytes 1–4 are 12 34 56 78.
- Retrigger rules:
  - Stimulus: cpu_done held high 2 frames' worth of time.
  - Required: exactly one frame.
  - Stimulus: cpu_done pulsed 0->1 mid-frame.
  - Required: ignored.
  - Stimulus: cpu_done low then high after DONE.
  - Required: second frame sent.
- Reset mid-frame:
  - Stimulus: rstn low after byte 10 is accepted.
  - Required: all outputs 0 asynchronously; no frame_done; cpu_done still high after release gives no frame.
  - Stimulus: a fresh cpu_done rising edge.
  - Required: full 34-byte frame starting with A5.
- Checksum:
  - Stimulus: all counters 32'hFFFFFFFF.
  - Required: checksum 00.
  - Stimulus: only counter7 = 32'h000000AA, others 0.
  - Required: checksum AA.

Source files
------------

// File: rtl/perf_frame_serializer_pkg.sv
// Shared types and defaults for the performance counter frame serializer.
// Imported by the byte mux and the top level.
package perf_frame_serializer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        CSUM,
        DONE
    } state_t;

    localparam int         DEF_NUM_CNT   = 8;
    localparam int         DEF_CNT_W     = 32;
    localparam logic [7:0] DEF_HEADER    = 8'hA5;
    localparam int         BYTES_PER_CNT = DEF_CNT_W / 8;
    localparam int         DATA_BYTES    = DEF_NUM_CNT * BYTES_PER_CNT;

endpackage

// File: rtl/perf_byte_mux.sv
// Selects data byte idx from the counter snapshot.
// Counters go in index order, each one MSB byte first.
module perf_byte_mux
    import perf_frame_serializer_pkg::*;
#(
    parameter int NUM_CNT = DEF_NUM_CNT,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int IDX_W   = 5
) (
    input  logic [NUM_CNT*CNT_W-1:0] snap,
    input  logic [IDX_W-1:0]         idx,
    output logic [7:0]               data_byte
);

    localparam int BPC = CNT_W / 8;
    localparam int NB  = NUM_CNT * BPC;

    logic [7:0] lane [NB];

    for (genvar b = 0; b < NB; b++) begin : g_lane
        localparam int C = b / BPC;
        localparam int S = BPC - 1 - (b % BPC);
        assign lane[b] = snap[C*CNT_W + S*8 +: 8];
    end

    // byte lookup in frame order
    always_comb begin
        data_byte = '0;
        if (int'(idx) < NB) begin
            data_byte = lane[idx];
        end
    end

endmodule

// File: rtl/perf_frame_serializer.sv
// Snapshots the counter bank on a cpu_done rising edge and streams
// header, counter bytes and an XOR checksum over a valid/ready byte port.
module perf_frame_serializer
    import perf_frame_serializer_pkg::*;
#(
    parameter int         NUM_CNT = DEF_NUM_CNT,
    parameter int         CNT_W   = DEF_CNT_W,
    parameter logic [7:0] HEADER  = DEF_HEADER
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cpu_done,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_i,
    input  logic                     tx_ready,
    output logic                     tx_valid,
    output logic [7:0]               tx_byte,
    output logic                     frame_busy,
    output logic                     frame_done
);

    localparam int BPC   = CNT_W / 8;
    localparam int NB    = NUM_CNT * BPC;
    localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    state_t                   state_q;
    state_t                   state_d;
    logic [NUM_CNT*CNT_W-1:0] snap_q;
    logic [IDX_W-1:0]         idx_q;
    logic [7:0]               csum_q;
    logic [7:0]               data_byte;
    logic                     cpu_done_d;
    logic                     trig;
    logic                     accept;

    assign trig   = cpu_done & ~cpu_done_d;
    assign accept = tx_valid & tx_ready;

    perf_byte_mux #(
        .NUM_CNT (NUM_CNT),
        .CNT_W   (CNT_W),
        .IDX_W   (IDX_W)
    ) u_mux (
        .snap      (snap_q),
        .idx       (idx_q),
        .data_byte (data_byte)
    );

    // cpu_done history; reset high so a level held through reset is not an edge
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cpu_done_d <= 1'b1;
        end else begin
            cpu_done_d <= cpu_done;
        end
    end

    // frame state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // next state and outputs, all decoded from the current state
    always_comb begin
        state_d    = state_q;
        tx_valid   = 1'b0;
        tx_byte    = '0;
        frame_busy = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (trig) state_d = HDR;
            end
            HDR: begin
                tx_valid   = 1'b1;
                tx_byte    = HEADER;
                frame_busy = 1'b1;
                if (tx_ready) state_d = DATA;
            end
            DATA: begin
                tx_valid   = 1'b1;
                tx_byte    = data_byte;
                frame_busy = 1'b1;
                if (tx_ready && idx_q == LAST_IDX) state_d = CSUM;
            end
            CSUM: begin
                tx_valid   = 1'b1;
                tx_byte    = csum_q;
                frame_busy = 1'b1;
                if (tx_ready) state_d = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // snapshot capture, byte index and running checksum
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            snap_q <= '0;
            idx_q  <= '0;
            csum_q <= '0;
        end else if (state_q == IDLE && trig) begin
            snap_q <= cnt_i;
            idx_q  <= '0;
            csum_q <= '0;
        end else if (state_q == DATA && accept) begin
            csum_q <= csum_q ^ data_byte;
            idx_q  <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_perf_frame_serializer.sv
// Scoreboard bench for perf_frame_serializer: a frame model fills a byte
// queue, a monitor pops and compares on every accepted byte.
`timescale 1ns/1ps
module tb_perf_frame_serializer;

    localparam int NC = 8;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             cpu_done = 1'b0;
    logic             tx_ready = 1'b0;
    logic [NC*CW-1:0] cnt_i = '0;
    logic             tx_valid;
    logic [7:0]       tx_byte;
    logic             frame_busy;
    logic             frame_done;

    perf_frame_serializer dut (
        .clk        (clk),
        .rstn       (rstn),
        .cpu_done   (cpu_done),
        .cnt_i      (cnt_i),
        .tx_ready   (tx_ready),
        .tx_valid   (tx_valid),
        .tx_byte    (tx_byte),
        .frame_busy (frame_busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] exp_q[$];
    int         n_bytes = 0;
    int         n_done = 0;
    logic [7:0] last_byte = '0;
    int         rdy_mode = 0;
    logic [31:0] cv [NC];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic load();
        for (int k = 0; k < NC; k++) cnt_i[k*CW +: CW] = cv[k];
    endtask

    // reference frame: header, counters MSB byte first, XOR of data bytes
    task automatic push_frame();
        logic [7:0] cs;
        logic [7:0] b;
        cs = 8'h00;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < NC; k++) begin
            for (int j = CW/8 - 1; j >= 0; j--) begin
                b = 8'((cv[k] >> (8*j)) & 32'hFF);
                exp_q.push_back(b);
                cs = cs ^ b;
            end
        end
        exp_q.push_back(cs);
    endtask

    // tx_ready driver: 0 always, 1 one cycle in ten, 2 random
    initial begin
        int phase;
        phase = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: tx_ready = 1'b1;
                1: begin
                    phase = (phase + 1) % 10;
                    tx_ready = (phase == 0);
                end
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // monitor: compare accepted bytes, check stall hold and done width
    initial begin
        logic       pv;
        logic       pa;
        logic       pd;
        logic [7:0] pb;
        pv = 1'b0; pa = 1'b0; pd = 1'b0; pb = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                pv = 1'b0;
                pd = 1'b0;
                continue;
            end
            if (pv && !pa) begin
                chk("hold_valid", 32'(tx_valid), 32'd1);
                chk("hold_byte", 32'(tx_byte), 32'(pb));
            end
            if (pd) chk("done_width", 32'(frame_done), 32'd0);
            if (frame_done) n_done++;
            if (tx_valid && tx_ready) begin
                n_bytes++;
                last_byte = tx_byte;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_byte: got %0h expected none",
                             tx_byte);
                end else begin
                    chk("byte", 32'(tx_byte), 32'(exp_q.pop_front()));
                end
            end
            pv = tx_valid;
            pa = tx_valid && tx_ready;
            pb = tx_byte;
            pd = frame_done;
        end
    end

    task automatic idle_check(input int cycles);
        int b0;
        int d0;
        b0 = n_bytes;
        d0 = n_done;
        repeat (cycles) @(negedge clk);
        chk("no_frame_bytes", 32'(n_bytes - b0), 32'd0);
        chk("no_frame_done", 32'(n_done - d0), 32'd0);
        chk("idle_valid", 32'(tx_valid), 32'd0);
        chk("idle_byte", 32'(tx_byte), 32'd0);
    endtask

    task automatic run_frame(input int mode, input bit check_lat,
                             input int corrupt_at, input int pulse_at,
                             input bit done_edge, input bit keep_high);
        int n;
        bit busy_ok;
        bit seen;
        int d0;
        n = 0; busy_ok = 1'b1; seen = 1'b0; d0 = n_done;
        rdy_mode = mode;
        load();
        push_frame();
        @(posedge clk); #1 cpu_done = 1'b0;
        @(posedge clk); #1 cpu_done = 1'b1;
        while (n < 3000) begin
            @(negedge clk);
            n++;
            if (frame_done) begin
                seen = 1'b1;
                if (done_edge) cpu_done = 1'b1;
                break;
            end
            if (n >= 2 && !frame_busy) busy_ok = 1'b0;
            if (n == corrupt_at) cnt_i = '1;
            if (n == pulse_at) cpu_done = 1'b0;
            if (pulse_at > 0 && n == pulse_at + 2) cpu_done = 1'b1;
            if (done_edge && n == 34) cpu_done = 1'b0;
        end
        chk("frame_done_seen", 32'(seen), 32'd1);
        if (check_lat) chk("done_latency", 32'(n), 32'd36);
        chk("busy_during_frame", 32'(busy_ok), 32'd1);
        @(negedge clk);
        chk("busy_after_done", 32'(frame_busy), 32'd0);
        chk("done_pulses", 32'(n_done - d0), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        if (!keep_high) cpu_done = 1'b0;
    endtask

    initial begin
        int b0;
        int d0;
        int n;

        // reset state with cpu_done already high
        cpu_done = 1'b1;
        #3;
        chk("rst_valid", 32'(tx_valid), 32'd0);
        chk("rst_byte", 32'(tx_byte), 32'd0);
        chk("rst_busy", 32'(frame_busy), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        idle_check(40);

        // basic frame
        for (int k = 0; k < NC; k++) cv[k] = 32'(k + 1);
        run_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);
        chk("basic_csum", 32'(last_byte), 32'h08);

        // back-pressure
        run_frame(1, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("bp_csum", 32'(last_byte), 32'h08);

        // snapshot isolation: counters overwritten early in a slow frame
        cv[0] = 32'h12345678;
        for (int k = 1; k < NC; k++) cv[k] = $urandom;
        run_frame(1, 1'b0, 10, -1, 1'b0, 1'b0);

        // cpu_done held high: one frame only
        for (int k = 0; k < NC; k++) cv[k] = $urandom;
        run_frame(0, 1'b1, -1, -1, 1'b0, 1'b1);
        idle_check(80);

        // rising edge mid-frame ignored
        for (int k = 0; k < NC; k++) cv[k] = $urandom;
        run_frame(2, 1'b0, -1, 15, 1'b0, 1'b1);
        idle_check(80);

        // rising edge in the DONE cycle ignored
        run_frame(0, 1'b1, -1, -1, 1'b1, 1'b1);
        idle_check(60);

        // low then high again gives a second frame
        run_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);

        // reset after byte 10
        for (int k = 0; k < NC; k++) cv[k] = $urandom;
        load();
        push_frame();
        rdy_mode = 0;
        b0 = n_bytes;
        d0 = n_done;
        @(posedge clk); #1 cpu_done = 1'b0;
        @(posedge clk); #1 cpu_done = 1'b1;
        n = 0;
        while (n_bytes - b0 < 11 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_byte10", 32'(n_bytes - b0 >= 11), 32'd1);
        @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("midrst_valid", 32'(tx_valid), 32'd0);
        chk("midrst_byte", 32'(tx_byte), 32'd0);
        chk("midrst_busy", 32'(frame_busy), 32'd0);
        chk("midrst_done", 32'(frame_done), 32'd0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        idle_check(60);
        chk("midrst_no_done", 32'(n_done - d0), 32'd0);
        run_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);

        // checksum corners
        for (int k = 0; k < NC; k++) cv[k] = 32'hFFFF_FFFF;
        run_frame(0, 1'b1, -1, -1, 1'b0, 1'b0);
        chk("csum_all_ones", 32'(last_byte), 32'h00);
        for (int k = 0; k < NC; k++) cv[k] = 32'h0;
        cv[7] = 32'h0000_00AA;
        run_frame(2, 1'b0, -1, -1, 1'b0, 1'b0);
        chk("csum_aa", 32'(last_byte), 32'hAA);

        // random frames under random back-pressure
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NC; k++) cv[k] = $urandom;
            run_frame(2, 1'b0, -1, -1, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
